soml_symbol_slicer: RTL

- Downstream stage of the SOML decoder's per-symbol estimate path (xI/xQ computation after the qdiv normalisation).
- Takes Q8.8 signed I/Q soft estimates, one symbol per accepted beat, and hard-slices each to a 16-QAM Gray-coded 4-bit label.
- Packs SYMS labels, one space-time block, into a single output word with valid/ready handshake toward the bit sink.
- Carries a per-symbol erasure flag when the upstream divider reports overflow.

---
 rtl/soml_pkg.sv | 21 ++
 rtl/soml_symbol_slicer_qam16_axis_slice.sv | 27 ++
 rtl/soml_symbol_slicer.sv | 116 +++++++++++
 3 files changed

// File: rtl/soml_pkg.sv
// Shared constants for the SOML symbol slicer: Q8.8 format, default decision
// threshold, 16-QAM Gray codes and the slicer state encoding.
package soml_pkg;

    localparam int FRAC   = 8;
    localparam int SOFT_W = 16;

    // +2.0 in Q8.8
    localparam logic signed [SOFT_W-1:0] THRESH_DEF = 16'sh0200;

    localparam logic [1:0] G_M3 = 2'b00;
    localparam logic [1:0] G_M1 = 2'b01;
    localparam logic [1:0] G_P1 = 2'b11;
    localparam logic [1:0] G_P3 = 2'b10;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } slicer_state_t;

endpackage

// File: rtl/soml_symbol_slicer_qam16_axis_slice.sv
// One-axis 16-QAM hard decision: signed soft value to 2-bit Gray label.
// Ties resolve upward (0 -> +1, +THRESH -> +3, -THRESH -> -1).
module qam16_axis_slice
    import soml_pkg::*;
#(
    parameter int                     W      = SOFT_W,
    parameter logic signed [W-1:0]    THRESH = THRESH_DEF
) (
    input  logic signed [W-1:0] v,
    output logic [1:0]          gray
);

    localparam logic signed [W-1:0] NEG_THRESH = -THRESH;

    always_comb begin
        if (v < NEG_THRESH) begin
            gray = G_M3;
        end else if (v[W-1]) begin
            gray = G_M1;
        end else if (v < THRESH) begin
            gray = G_P1;
        end else begin
            gray = G_P3;
        end
    end

endmodule

// File: rtl/soml_symbol_slicer.sv
// Slices I/Q soft estimates to 16-QAM Gray labels and packs SYMS labels plus
// per-symbol erase flags into one output word with valid/ready toward the sink.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | accepting symbols into slots 0..SYMS-1, out_valid low
// HOLD    | packed block presented; input accepted only with out_ready
module soml_symbol_slicer
    import soml_pkg::*;
#(
    parameter int                     W      = SOFT_W,
    parameter logic signed [W-1:0]    THRESH = THRESH_DEF,
    parameter int                     SYMS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W-1:0]   in_xi,
    input  logic signed [W-1:0]   in_xq,
    input  logic                  in_ovf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*SYMS-1:0]     out_bits,
    output logic [SYMS-1:0]       out_erase
);

    localparam int              CW   = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam logic [CW-1:0]   LAST = CW'(SYMS - 1);

    logic [1:0]          gray_i;
    logic [1:0]          gray_q;
    logic [3:0]          label;

    slicer_state_t       state;
    slicer_state_t       state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       wr_slot;
    logic                accept;
    logic                complete;
    logic [4*SYMS-1:0]   buf_bits;
    logic [4*SYMS-1:0]   buf_bits_nxt;
    logic [SYMS-1:0]     buf_erase;
    logic [SYMS-1:0]     buf_erase_nxt;

    qam16_axis_slice #(.W(W), .THRESH(THRESH)) u_slice_i (
        .v    (in_xi),
        .gray (gray_i)
    );

    qam16_axis_slice #(.W(W), .THRESH(THRESH)) u_slice_q (
        .v    (in_xq),
        .gray (gray_q)
    );

    assign label = in_ovf ? 4'b0000 : {gray_i, gray_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // A symbol accepted in HOLD (sink draining the block) starts the next block at slot 0.
    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b1;
        out_valid     = 1'b0;
        wr_slot       = cnt;
        accept        = 1'b0;
        complete      = 1'b0;
        buf_bits_nxt  = buf_bits;
        buf_erase_nxt = buf_erase;

        if (state == HOLD) begin
            in_ready  = out_ready;
            out_valid = 1'b1;
            wr_slot   = '0;
            if (out_ready) begin
                state_nxt = COLLECT;
            end
        end

        accept   = in_valid && in_ready;
        complete = accept && (wr_slot == LAST);
        if (complete) begin
            state_nxt = HOLD;
        end

        buf_bits_nxt[4*wr_slot +: 4] = label;
        buf_erase_nxt[wr_slot]       = in_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            buf_bits  <= '0;
            buf_erase <= '0;
            out_bits  <= '0;
            out_erase <= '0;
        end else begin
            if (accept) begin
                buf_bits  <= buf_bits_nxt;
                buf_erase <= buf_erase_nxt;
                cnt       <= complete ? '0 : wr_slot + CW'(1);
            end
            if (complete) begin
                out_bits  <= buf_bits_nxt;
                out_erase <= buf_erase_nxt;
            end
        end
    end

endmodule
